// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared constants and FSM state type for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_XOR = 3'b100;
    localparam logic [2:0] ALUC_SLT = 3'b101;
    localparam logic [2:0] ALUC_SLL = 3'b110;
    localparam logic [2:0] ALUC_MUL = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_if
// Description : ID/EX inputs and EX/MEM outputs of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_if #(
    parameter int DW = 32
);
    logic [DW-1:0] Ex_D1;
    logic [DW-1:0] Ex_D2;
    logic [DW-1:0] Ex_Extimm;
    logic [DW-1:0] Ex_Pc;
    logic [5:0]    Ex_Op;
    logic [4:0]    Ex_Rd;
    logic [2:0]    Ex_Aluc;
    logic          Ex_Aluqb;
    logic [1:0]    Ex_Fwd_A;
    logic [1:0]    Ex_Fwd_B;
    logic          Ex_Wreg;
    logic          Ex_Reg2reg;
    logic          Ex_Wmem;
    logic [DW-1:0] Wb_Data;

    logic          busy;
    logic          condition_met;
    logic [DW-1:0] Branch_Pc;
    logic [DW-1:0] Mem_Alu_Out;
    logic [DW-1:0] Mem_Store_Data;
    logic [4:0]    Mem_Rd;
    logic          Mem_Wreg;
    logic          Mem_Reg2reg;
    logic          Mem_Wmem;

    modport master (
        output Ex_D1, Ex_D2, Ex_Extimm, Ex_Pc, Ex_Op, Ex_Rd, Ex_Aluc, Ex_Aluqb,
               Ex_Fwd_A, Ex_Fwd_B, Ex_Wreg, Ex_Reg2reg, Ex_Wmem, Wb_Data,
        input  busy, condition_met, Branch_Pc, Mem_Alu_Out, Mem_Store_Data,
               Mem_Rd, Mem_Wreg, Mem_Reg2reg, Mem_Wmem
    );

    modport slave (
        input  Ex_D1, Ex_D2, Ex_Extimm, Ex_Pc, Ex_Op, Ex_Rd, Ex_Aluc, Ex_Aluqb,
               Ex_Fwd_A, Ex_Fwd_B, Ex_Wreg, Ex_Reg2reg, Ex_Wmem, Wb_Data,
        output busy, condition_met, Branch_Pc, Mem_Alu_Out, Mem_Store_Data,
               Mem_Rd, Mem_Wreg, Mem_Reg2reg, Mem_Wmem
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_iter
// Description : Iterative shift-add multiplier, MUL_STEP bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MUL_STEP = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);
    localparam int unsigned N  = DW / MUL_STEP;
    localparam int          CW = $clog2(N + 1);

    mul_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] step_sum;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // DONE always returns to IDLE so a still-visible mul opcode is not re-issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (count_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_sum = acc_q;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) step_sum = step_sum + (mcand_q << k);
        end
        if (state_q == IDLE && start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = CW'(N);
        end else if (state_q == MUL) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            count_d  = count_q - CW'(1);
        end
        busy    = (state_q == IDLE && start) || (state_q == MUL);
        done    = (state_q == DONE);
        product = acc_q;
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage - forwarding, ALU, BEQ resolve, EX/MEM register.
//               Define EX_MUL_EN to include the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MUL_STEP = 1
) (
    input  logic clk,
    input  logic clr,
    ex_if.slave  bus
);
    logic [DW-1:0] fwd_a, fwd_b, op_b;
    logic [DW-1:0] alu_result, ex_result;
    logic          mul_busy, mul_done;
    logic [DW-1:0] mul_product;

    logic [DW-1:0] mem_alu_out_q, mem_alu_out_d;
    logic [DW-1:0] mem_store_q, mem_store_d;
    logic [4:0]    mem_rd_q, mem_rd_d;
    logic          mem_wreg_q, mem_wreg_d;
    logic          mem_reg2reg_q, mem_reg2reg_d;
    logic          mem_wmem_q, mem_wmem_d;

    always_comb begin
        case (bus.Ex_Fwd_A)
            FWD_REG: fwd_a = bus.Ex_D1;
            FWD_MEM: fwd_a = mem_alu_out_q;
            FWD_WB:  fwd_a = bus.Wb_Data;
            default: fwd_a = bus.Ex_D1;
        endcase
        case (bus.Ex_Fwd_B)
            FWD_REG: fwd_b = bus.Ex_D2;
            FWD_MEM: fwd_b = mem_alu_out_q;
            FWD_WB:  fwd_b = bus.Wb_Data;
            default: fwd_b = bus.Ex_D2;
        endcase
        op_b = bus.Ex_Aluqb ? fwd_b : bus.Ex_Extimm;
    end

    always_comb begin
        alu_result = '0;
        case (bus.Ex_Aluc)
            ALUC_ADD: alu_result = fwd_a + op_b;
            ALUC_SUB: alu_result = fwd_a - op_b;
            ALUC_AND: alu_result = fwd_a & op_b;
            ALUC_OR:  alu_result = fwd_a | op_b;
            ALUC_XOR: alu_result = fwd_a ^ op_b;
            ALUC_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            ALUC_SLL: alu_result = fwd_a << op_b[4:0];
            ALUC_MUL: alu_result = '0;
            default:  alu_result = '0;
        endcase
    end

`ifdef EX_MUL_EN
    ex_mul_iter #(
        .DW       (DW),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .clr     (clr),
        .start   (bus.Ex_Aluc == ALUC_MUL),
        .a       (fwd_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic [MUL_STEP-1:0] unused_mul_step;
    assign unused_mul_step = '0;
    assign mul_busy        = 1'b0;
    assign mul_done        = 1'b0;
    assign mul_product     = '0;
`endif

    assign ex_result = mul_done ? mul_product : alu_result;

    // A busy cycle inserts a bubble but leaves the last result visible for forwarding
    always_comb begin
        mem_alu_out_d = mem_alu_out_q;
        mem_store_d   = mem_store_q;
        mem_rd_d      = '0;
        mem_wreg_d    = 1'b0;
        mem_reg2reg_d = 1'b0;
        mem_wmem_d    = 1'b0;
        if (!mul_busy) begin
            mem_alu_out_d = ex_result;
            mem_store_d   = fwd_b;
            mem_rd_d      = bus.Ex_Rd;
            mem_wreg_d    = bus.Ex_Wreg;
            mem_reg2reg_d = bus.Ex_Reg2reg;
            mem_wmem_d    = bus.Ex_Wmem;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem_alu_out_q <= '0;
            mem_store_q   <= '0;
            mem_rd_q      <= '0;
            mem_wreg_q    <= 1'b0;
            mem_reg2reg_q <= 1'b0;
            mem_wmem_q    <= 1'b0;
        end else begin
            mem_alu_out_q <= mem_alu_out_d;
            mem_store_q   <= mem_store_d;
            mem_rd_q      <= mem_rd_d;
            mem_wreg_q    <= mem_wreg_d;
            mem_reg2reg_q <= mem_reg2reg_d;
            mem_wmem_q    <= mem_wmem_d;
        end
    end

    assign bus.busy           = mul_busy;
    assign bus.condition_met  = (bus.Ex_Op == OP_BEQ) && (fwd_a == fwd_b) && !mul_busy;
    assign bus.Branch_Pc      = bus.Ex_Pc;
    assign bus.Mem_Alu_Out    = mem_alu_out_q;
    assign bus.Mem_Store_Data = mem_store_q;
    assign bus.Mem_Rd         = mem_rd_q;
    assign bus.Mem_Wreg       = mem_wreg_q;
    assign bus.Mem_Reg2reg    = mem_reg2reg_q;
    assign bus.Mem_Wmem       = mem_wmem_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed, table-driven bench for ex_stage (EX_MUL_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_if #(.DW(32)) bus ();

    ex_stage #(.DW(32), .MUL_STEP(1)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] d1, d2, imm, pc, wb;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [2:0]  aluc;
        logic        aluqb;
        logic [1:0]  fa, fb;
        logic        wreg, r2r, wmem;
        logic        exp_cond;
        logic [31:0] exp_out, exp_store;
    } vec_t;

    vec_t vecs[14];
    int   nvec;

    function automatic vec_t mk(
        input logic [31:0] d1, d2, imm, pc, wb,
        input logic [5:0]  op,
        input logic [4:0]  rd,
        input logic [2:0]  aluc,
        input logic        aluqb,
        input logic [1:0]  fa, fb,
        input logic        wreg, r2r, wmem, exp_cond,
        input logic [31:0] exp_out, exp_store
    );
        vec_t v;
        v.d1 = d1; v.d2 = d2; v.imm = imm; v.pc = pc; v.wb = wb;
        v.op = op; v.rd = rd; v.aluc = aluc; v.aluqb = aluqb;
        v.fa = fa; v.fb = fb; v.wreg = wreg; v.r2r = r2r; v.wmem = wmem;
        v.exp_cond = exp_cond; v.exp_out = exp_out; v.exp_store = exp_store;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.Ex_D1 = v.d1; bus.Ex_D2 = v.d2; bus.Ex_Extimm = v.imm; bus.Ex_Pc = v.pc;
        bus.Wb_Data = v.wb; bus.Ex_Op = v.op; bus.Ex_Rd = v.rd; bus.Ex_Aluc = v.aluc;
        bus.Ex_Aluqb = v.aluqb; bus.Ex_Fwd_A = v.fa; bus.Ex_Fwd_B = v.fb;
        bus.Ex_Wreg = v.wreg; bus.Ex_Reg2reg = v.r2r; bus.Ex_Wmem = v.wmem;
    endtask

`ifdef EX_MUL_EN
    // Operand A arrives through the WB forwarding path, which is scrambled while busy.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input logic [31:0] prev_out);
        int cycles;
        apply(mk(32'hBAD0_0001, b, 32'h0, 32'h0, a, 6'd0, rd, 3'b111, 1'b1,
                 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        #1;
        chk({tag, "_busy_at_issue"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_no_branch_busy"}, {31'd0, bus.condition_met}, 32'd0);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
            bus.Wb_Data = 32'h5A5A_5A5A;
            chk({tag, "_bubble_ctrl"},
                {24'd0, bus.Mem_Wreg, bus.Mem_Wmem, bus.Mem_Reg2reg, bus.Mem_Rd}, 32'd0);
            chk({tag, "_bubble_hold"}, bus.Mem_Alu_Out, prev_out);
        end
        chk({tag, "_busy_cycles"}, cycles, 32'd33);
        @(posedge clk); #1;
        chk({tag, "_product"}, bus.Mem_Alu_Out, exp);
        chk({tag, "_wreg"}, {31'd0, bus.Mem_Wreg}, 32'd1);
        chk({tag, "_rd"}, {27'd0, bus.Mem_Rd}, {27'd0, rd});
        chk({tag, "_store"}, bus.Mem_Store_Data, b);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with non-zero inputs pending: every EX/MEM field must stay 0
        apply(mk(32'h1234, 32'h55, 32'h7, 32'h0, 32'h0, 6'd0, 5'd31, 3'b000, 1'b1,
                 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_out", bus.Mem_Alu_Out, 32'h0);
        chk("rst_store",   bus.Mem_Store_Data, 32'h0);
        chk("rst_rd",      {27'd0, bus.Mem_Rd}, 32'h0);
        chk("rst_ctrl",    {29'd0, bus.Mem_Wreg, bus.Mem_Reg2reg, bus.Mem_Wmem}, 32'h0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        //          d1            d2            imm         pc          wb          op     rd     aluc    qb    fa     fb     wr   r2r  wm   cond  out           store
        vecs[0]  = mk(32'h0000000C, 32'h00000055, 32'd4,      32'h0,      32'h0,      6'd0,  5'd1,  3'b000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000010, 32'h00000055);
        vecs[1]  = mk(32'h00000005, 32'h00000003, 32'd0,      32'h0,      32'h0,      6'd0,  5'd2,  3'b000, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000013, 32'h00000003);
        vecs[2]  = mk(32'hFFFFFFFF, 32'h00000000, 32'd1,      32'h0,      32'h0,      6'd0,  5'd3,  3'b101, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000000);
        vecs[3]  = mk(32'h00000007, 32'h00000007, 32'd0,      32'h40,     32'h0,      6'd4,  5'd0,  3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000007);
        vecs[4]  = mk(32'h00000007, 32'h00000008, 32'd0,      32'h40,     32'h0,      6'd4,  5'd0,  3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000008);
        vecs[5]  = mk(32'h0000F0F0, 32'h00001234, 32'd0,      32'h0,      32'h0FF0,   6'd0,  5'd4,  3'b010, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000000F0, 32'h00000FF0);
        vecs[6]  = mk(32'h00000100, 32'h00000001, 32'd0,      32'h0,      32'h0,      6'd0,  5'd5,  3'b011, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000101, 32'h00000001);
        vecs[7]  = mk(32'hFF00FF00, 32'h0FF00FF0, 32'd0,      32'h80,     32'h0,      6'd4,  5'd6,  3'b100, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0);
        vecs[8]  = mk(32'h00000001, 32'h00000000, 32'd31,     32'h0,      32'h0,      6'd0,  5'd7,  3'b110, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h00000000);
        vecs[9]  = mk(32'h00000005, 32'hFFFFFFFD, 32'd0,      32'h0,      32'h0,      6'd0,  5'd8,  3'b101, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'hFFFFFFFD);
        vecs[10] = mk(32'h00000099, 32'h00000001, 32'd0,      32'h0,      32'h0,      6'd0,  5'd9,  3'b001, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        vecs[11] = mk(32'h00000000, 32'h00000077, 32'd0,      32'h0,      32'h0,      6'd0,  5'd10, 3'b001, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFF);
        vecs[12] = mk(32'h00000000, 32'h00000001, 32'd0,      32'h44,     32'h0,      6'd4,  5'd0,  3'b000, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000002, 32'h00000001);
        nvec = 13;
`ifndef EX_MUL_EN
        vecs[13] = mk(32'd12345,    32'd678,      32'd0,      32'h0,      32'h0,      6'd0,  5'd11, 3'b111, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'd678);
        nvec = 14;
`endif

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_cond", i), {31'd0, bus.condition_met}, {31'd0, vecs[i].exp_cond});
            chk($sformatf("v%0d_bpc", i), bus.Branch_Pc, vecs[i].pc);
            chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out", i), bus.Mem_Alu_Out, vecs[i].exp_out);
            chk($sformatf("v%0d_store", i), bus.Mem_Store_Data, vecs[i].exp_store);
            chk($sformatf("v%0d_rd", i), {27'd0, bus.Mem_Rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_ctrl", i), {29'd0, bus.Mem_Wreg, bus.Mem_Reg2reg, bus.Mem_Wmem},
                {29'd0, vecs[i].wreg, vecs[i].r2r, vecs[i].wmem});
        end

`ifdef EX_MUL_EN
        do_mul("mul1", 32'd12345, 32'd678, 5'd12, 32'd8369910, 32'h00000002);
        do_mul("mul2", 32'hFFFFFFFF, 32'd2, 5'd13, 32'hFFFFFFFE, 32'd8369910);

        // Abort a multiply mid-flight with clr
        apply(mk(32'd3, 32'd4, 32'h0, 32'h0, 32'h0, 6'd0, 5'd14, 3'b111, 1'b1,
                 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        #1;
        chk("abort_busy_issue", {31'd0, bus.busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_mid", {31'd0, bus.busy}, 32'd1);
        clr = 1'b1;
        bus.Ex_Aluc = 3'b000;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_out", bus.Mem_Alu_Out, 32'h0);
        chk("abort_store", bus.Mem_Store_Data, 32'h0);
        chk("abort_ctrl", {24'd0, bus.Mem_Wreg, bus.Mem_Wmem, bus.Mem_Reg2reg, bus.Mem_Rd}, 32'h0);
        apply(mk(32'd2, 32'd3, 32'h0, 32'h0, 32'h0, 6'd0, 5'd15, 3'b000, 1'b1,
                 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
        @(posedge clk); #1;
        chk("post_abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_abort_out", bus.Mem_Alu_Out, 32'd5);
        chk("post_abort_rd", {27'd0, bus.Mem_Rd}, 32'd15);
`else
        // Mul opcode held for several cycles: never busy, result stays 0
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("nomul_busy%0d", i), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("nomul_out%0d", i), bus.Mem_Alu_Out, 32'h0);
            chk($sformatf("nomul_wreg%0d", i), {31'd0, bus.Mem_Wreg}, 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
